// File: rtl/batpu_screen_io_if.sv
// Command/read bus between the BatPU core and the screen peripheral.
// The CPU side drives requests; the screen side answers with ready and read data.
interface batpu_screen_io_if;
  logic       wr_en;
  logic       wr_ready;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  wr_ready, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output wr_ready, rd_data
  );
endinterface

// File: rtl/batpu_screen_io.sv
// BatPU screen peripheral: 32x32 back buffer drawn by the CPU, front buffer
// loaded on push and scanned out one row per cycle, plus a row-walking clear.
module batpu_screen_io #(
  parameter int BASE_ADDR  = 240,
  parameter int CLEAR_ROWS = 32
) (
  input  logic                clkin,
  input  logic                rst,
  batpu_screen_io_if.slave    bus,
  input  logic [4:0]          scan_row,
  output logic [31:0]         scan_line,
  output logic                push_pulse,
  output logic [7:0]          frame_cnt
);

  localparam logic [7:0] BASE     = 8'(BASE_ADDR);
  localparam logic [4:0] LAST_ROW = 5'(CLEAR_ROWS - 1);

  // Register offsets from BASE.
  localparam logic [7:0] OFF_X     = 8'd0;
  localparam logic [7:0] OFF_Y     = 8'd1;
  localparam logic [7:0] OFF_SET   = 8'd2;
  localparam logic [7:0] OFF_CLR   = 8'd3;
  localparam logic [7:0] OFF_PIXEL = 8'd4;
  localparam logic [7:0] OFF_PUSH  = 8'd5;
  localparam logic [7:0] OFF_CLEAR = 8'd6;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state, state_next;
  logic [4:0]  x, y, row_cnt;
  logic [31:0] back  [32];
  logic [31:0] front [32];
  logic [7:0]  wr_off, rd_off;
  logic        wr_fire;
  logic        unused_data_bits;

  // Addresses below BASE wrap to large offsets and fall into the default arm.
  assign wr_off  = bus.wr_addr - BASE;
  assign rd_off  = bus.rd_addr - BASE;
  assign wr_fire = bus.wr_en && bus.wr_ready;

  // Coordinates are 5 bits wide; the upper data bits are intentionally ignored.
  assign unused_data_bits = &{1'b0, bus.wr_data[7:5]};

  // State register.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and ready: commands are only taken while idle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_next   = state;
    bus.wr_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.wr_ready = 1'b1;
        if (bus.wr_en && wr_off == OFF_CLEAR) state_next = CLEAR;
      end
      CLEAR: begin
        if (row_cnt == LAST_ROW) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Cursor, back buffer and clear walker.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      row_cnt <= '0;
      // NOTE: the pixel arrays are reset because a reset must blank the screen; this keeps them in flops, not RAM.
      for (int r = 0; r < 32; r++) back[r] <= '0;
    end else if (state == CLEAR) begin
      back[row_cnt] <= '0;
      row_cnt       <= (row_cnt == LAST_ROW) ? 5'd0 : row_cnt + 5'd1;
    end else if (wr_fire) begin
      // NOTE: non-blocking assignments mean pixel commands use the cursor as it was before this edge.
      case (wr_off)
        OFF_X:     x <= bus.wr_data[4:0];
        OFF_Y:     y <= bus.wr_data[4:0];
        OFF_SET:   back[y][x] <= 1'b1;
        OFF_CLR:   back[y][x] <= 1'b0;
        OFF_CLEAR: row_cnt <= '0;
        default:   ;
      endcase
    end
  end

  // Front buffer snapshot, push strobe and frame counter.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      push_pulse <= 1'b0;
      frame_cnt  <= '0;
      for (int r = 0; r < 32; r++) front[r] <= '0;
    end else begin
      push_pulse <= wr_fire && wr_off == OFF_PUSH;
      if (wr_fire && wr_off == OFF_PUSH) begin
        for (int r = 0; r < 32; r++) front[r] <= back[r];
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // Registered read port; holds its value between read requests.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
    end else if (bus.rd_en) begin
      case (rd_off)
        OFF_X:     bus.rd_data <= {3'b0, x};
        OFF_Y:     bus.rd_data <= {3'b0, y};
        OFF_PIXEL: bus.rd_data <= {7'b0, back[y][x]};
        OFF_PUSH:  bus.rd_data <= frame_cnt;
        default:   bus.rd_data <= '0;
      endcase
    end
  end

  // Scan-out: one front-buffer row per cycle.
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) scan_line <= '0;
    else     scan_line <= front[scan_row];
  end

endmodule
